regs_cmd_bridge: RTL and testbench
==================================

Name: regs_cmd_bridge

Overview:
- Byte-stream command bridge: parses read/write commands from an 8-bit receive stream and issues accesses on the master side of the registers memory bus (write_en/read_en/addr/write_data in; read_data/data_ready/write_done back).
- Returns one response byte per command on an 8-bit transmit stream.
- Sits directly upstream of the register memory slave, fed by the serial receiver and feeding the serial transmitter.

Parameters:
- DATA_DEPTH, 16, number of registers; valid addresses 0..DATA_DEPTH-1; max 256.
- DATA_WIDTH, 8, register data width; only 8 supported (one byte per data field).
- TIMEOUT_CYCLES, 1000, max cycles to wait for write_done/data_ready before aborting.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  incoming command byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  bridge accepts rx_data; a byte transfers on an edge with rx_valid&rx_ready.
- tx_data  output  8  response byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  consumer accepts tx_data.
- write_en  output  1  register write request.
- read_en  output  1  register read request.
- addr  output  $clog2(DATA_DEPTH)  register address.
- write_data  output  DATA_WIDTH  write payload.
- read_data  input  DATA_WIDTH  read payload from slave.
- data_ready  input  1  read_data valid.
- write_done  input  1  write completed.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rx_ready, tx_valid, write_en, read_en = 0; tx_data, addr, write_data = 0; timeout counter = 0. Reset mid-access aborts it immediately; no response is sent.
- Protocol: 0x57 ('W'), addr, data -> response 0x06 (ACK). 0x52 ('R'), addr -> response data byte. Any error -> response 0x15 (NAK).
- FSM states: IDLE, GET_ADDR, GET_DATA, WR_REQ, RD_REQ, SEND_RESP.
- IDLE (rx_ready=1):
  - 0x57 or 0x52 -> GET_ADDR, latch command.
  - Any other byte -> SEND_RESP with NAK.
- GET_ADDR (rx_ready=1): on byte, latch addr.
  - Byte >= DATA_DEPTH -> SEND_RESP NAK, no bus access.
  - Otherwise W -> GET_DATA; R -> RD_REQ.
- GET_DATA (rx_ready=1): on byte, latch write_data -> WR_REQ.
- rx_ready=0 in WR_REQ, RD_REQ, SEND_RESP. Bytes arriving then are not consumed.
- WR_REQ:
  - write_en=1 from the first cycle in state; addr and write_data held stable.
  - On the edge where write_done=1: write_en=0 next cycle, then SEND_RESP ACK.
- RD_REQ:
  - read_en=1; addr held.
  - On the edge where data_ready=1: capture read_data into tx_data, read_en=0 next cycle, then SEND_RESP with that byte.
- write_en and read_en are never high together.
- Timeout: counter clears on entering WR_REQ/RD_REQ and increments each cycle in state. When it reaches TIMEOUT_CYCLES without a handshake: drop the enable, send NAK.
- A handshake arriving on the same edge the counter would expire wins (ACK/data, not NAK).
- SEND_RESP:
  - tx_valid=1 with tx_data stable until the edge with tx_ready=1, then tx_valid=0 -> IDLE.
  - tx_ready may be held high indefinitely; exactly one byte per command.
- Minimum latency, zero-wait slave, tx_ready=1: write ACK tx_valid 2 cycles after the data byte is accepted; read response 2 cycles after the addr byte is accepted.
- write_done/data_ready outside the matching REQ state are ignored.

Optional Feature:
- Macro: REGS_CMD_BRIDGE_ERR_CNT_EN.
- Defined: extra output err_count [7:0]. Reset 0; increments by one each time a NAK is accepted by tx (tx_valid&tx_ready with NAK); saturates at 255.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Write: rx 0x57,0x03,0xA5; slave returns write_done 1 cycle after write_en -> write_en high with addr=3, write_data=0xA5 until write_done; tx 0x06.
- Read: rx 0x52,0x03; slave returns data_ready with read_data=0xA5 after 3 cycles -> read_en held 3 cycles; tx 0xA5; write_en never asserted.
- Bad command/address: rx 0x41 -> tx 0x15. Then rx 0x52,0x10 (DATA_DEPTH=16) -> tx 0x15, read_en never asserted. With macro: err_count=2.
- Timeout: TIMEOUT_CYCLES=8, slave silent on write -> write_en drops after 8 cycles; tx 0x15; next command processed normally.
- Backpressure: tx_ready low 5 cycles during read response -> tx_valid and tx_data stable throughout; rx_ready=0 until the response is accepted.
- Reset mid-read: rst_n low while read_en=1 -> read_en, tx_valid, rx_ready go 0 immediately; after release, FSM is in IDLE and a fresh write completes with ACK.

Source files
------------

// File: rtl/regs_cmd_bridge.sv
// regs_cmd_bridge: parses 'W' addr data / 'R' addr commands from a byte stream,
// drives the master side of the register bus and returns one response byte per command.
// Optional build macro REGS_CMD_BRIDGE_ERR_CNT_EN adds the saturating err_count output.
`timescale 1ns/1ps
module regs_cmd_bridge #(
   parameter int DATA_DEPTH     = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic                          write_en,
   output logic                          read_en,
   output logic [$clog2(DATA_DEPTH)-1:0] addr,
   output logic [DATA_WIDTH-1:0]         write_data,
   input  logic [DATA_WIDTH-1:0]         read_data,
   input  logic                          data_ready,
   input  logic                          write_done
`ifdef REGS_CMD_BRIDGE_ERR_CNT_EN
   ,
   output logic [7:0]                    err_count
`endif
);

   localparam int AW = $clog2(DATA_DEPTH);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] CMD_WR   = 8'h57;
   localparam logic [7:0] CMD_RD   = 8'h52;
   localparam logic [7:0] RESP_ACK = 8'h06;
   localparam logic [7:0] RESP_NAK = 8'h15;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_GET_ADDR  = 3'd1;
   localparam logic [2:0] ST_GET_DATA  = 3'd2;
   localparam logic [2:0] ST_WR_REQ    = 3'd3;
   localparam logic [2:0] ST_RD_REQ    = 3'd4;
   localparam logic [2:0] ST_SEND_RESP = 3'd5;

   // Last count value before the wait expires; a handshake on that edge still wins.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(TIMEOUT_CYCLES);

   function automatic logic is_cmd_byte(input logic [7:0] b);
      return (b == CMD_WR) || (b == CMD_RD);
   endfunction

   function automatic logic addr_in_range(input logic [7:0] b);
      return ({1'b0, b} < 9'(DATA_DEPTH));
   endfunction

   logic [2:0]            state_r,    state_s;
   logic                  is_write_r, is_write_s;
   logic [AW-1:0]         addr_r,     addr_s;
   logic [DATA_WIDTH-1:0] wdata_r,    wdata_s;
   logic [7:0]            tx_data_r,  tx_data_s;
   logic                  tx_valid_r, tx_valid_s;
   logic                  rx_ready_r, rx_ready_s;
   logic                  write_en_r, write_en_s;
   logic                  read_en_r,  read_en_s;
   logic [CW-1:0]         cnt_r,      cnt_s;
   logic                  rx_fire_s;
   logic                  tx_fire_s;

   assign rx_fire_s = rx_valid & rx_ready_r;
   assign tx_fire_s = tx_valid_r & tx_ready;

   // Next-state and next-output decode for the command FSM.
   always_comb begin
      state_s    = state_r;
      is_write_s = is_write_r;
      addr_s     = addr_r;
      wdata_s    = wdata_r;
      tx_data_s  = tx_data_r;
      tx_valid_s = 1'b0;
      write_en_s = 1'b0;
      read_en_s  = 1'b0;
      cnt_s      = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (rx_fire_s) begin
               if (is_cmd_byte(rx_data)) begin
                  is_write_s = (rx_data == CMD_WR);
                  state_s    = ST_GET_ADDR;
               end else begin
                  tx_data_s  = RESP_NAK;
                  tx_valid_s = 1'b1;
                  state_s    = ST_SEND_RESP;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GET_ADDR: begin
            if (rx_fire_s) begin
               addr_s = rx_data[AW-1:0];
               if (!addr_in_range(rx_data)) begin
                  tx_data_s  = RESP_NAK;
                  tx_valid_s = 1'b1;
                  state_s    = ST_SEND_RESP;
               end else if (is_write_r) begin
                  state_s = ST_GET_DATA;
               end else begin
                  read_en_s = 1'b1;
                  cnt_s     = {CW{1'b0}};
                  state_s   = ST_RD_REQ;
               end
            end else begin
               state_s = ST_GET_ADDR;
            end
         end
         ST_GET_DATA: begin
            if (rx_fire_s) begin
               wdata_s    = DATA_WIDTH'(rx_data);
               write_en_s = 1'b1;
               cnt_s      = {CW{1'b0}};
               state_s    = ST_WR_REQ;
            end else begin
               state_s = ST_GET_DATA;
            end
         end
         ST_WR_REQ: begin
            if (write_done) begin
               tx_data_s  = RESP_ACK;
               tx_valid_s = 1'b1;
               state_s    = ST_SEND_RESP;
            end else if (cnt_r == CNT_LAST) begin
               cnt_s      = CNT_FULL;
               tx_data_s  = RESP_NAK;
               tx_valid_s = 1'b1;
               state_s    = ST_SEND_RESP;
            end else begin
               cnt_s      = cnt_r + CW'(1);
               write_en_s = 1'b1;
            end
         end
         ST_RD_REQ: begin
            if (data_ready) begin
               tx_data_s  = 8'(read_data);
               tx_valid_s = 1'b1;
               state_s    = ST_SEND_RESP;
            end else if (cnt_r == CNT_LAST) begin
               cnt_s      = CNT_FULL;
               tx_data_s  = RESP_NAK;
               tx_valid_s = 1'b1;
               state_s    = ST_SEND_RESP;
            end else begin
               cnt_s     = cnt_r + CW'(1);
               read_en_s = 1'b1;
            end
         end
         ST_SEND_RESP: begin
            if (tx_fire_s) begin
               tx_valid_s = 1'b0;
               state_s    = ST_IDLE;
            end else begin
               tx_valid_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      rx_ready_s = (state_s == ST_IDLE) || (state_s == ST_GET_ADDR) || (state_s == ST_GET_DATA);
   end

   // State and registered outputs; reset aborts any access without a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         is_write_r <= 1'b0;
         addr_r     <= {AW{1'b0}};
         wdata_r    <= {DATA_WIDTH{1'b0}};
         tx_data_r  <= 8'h00;
         tx_valid_r <= 1'b0;
         rx_ready_r <= 1'b0;
         write_en_r <= 1'b0;
         read_en_r  <= 1'b0;
         cnt_r      <= {CW{1'b0}};
      end else begin
         state_r    <= state_s;
         is_write_r <= is_write_s;
         addr_r     <= addr_s;
         wdata_r    <= wdata_s;
         tx_data_r  <= tx_data_s;
         tx_valid_r <= tx_valid_s;
         rx_ready_r <= rx_ready_s;
         write_en_r <= write_en_s;
         read_en_r  <= read_en_s;
         cnt_r      <= cnt_s;
      end
   end

   assign rx_ready   = rx_ready_r;
   assign tx_data    = tx_data_r;
   assign tx_valid   = tx_valid_r;
   assign write_en   = write_en_r;
   assign read_en    = read_en_r;
   assign addr       = addr_r;
   assign write_data = wdata_r;

`ifdef REGS_CMD_BRIDGE_ERR_CNT_EN
   logic       resp_nak_r;
   logic [7:0] err_cnt_r;

   // Classify the pending response on entry to SEND_RESP: only a completed access is not a NAK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_nak_r <= 1'b0;
      end else if ((state_r != ST_SEND_RESP) && (state_s == ST_SEND_RESP)) begin
         resp_nak_r <= !((state_r == ST_WR_REQ) && write_done) &&
                       !((state_r == ST_RD_REQ) && data_ready);
      end else begin
         resp_nak_r <= resp_nak_r;
      end
   end

   // Count NAK bytes taken by the transmitter, saturating at the top value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_r <= 8'd0;
      end else if (tx_fire_s && resp_nak_r && (err_cnt_r != 8'hFF)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_count = err_cnt_r;
`endif

endmodule

// File: tb/tb_regs_cmd_bridge.sv
// Randomized self-checking bench for regs_cmd_bridge with a command-level reference model.
`timescale 1ns/1ps
module tb_regs_cmd_bridge;
   localparam int DEPTH = 16;
   localparam int TMO   = 8;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          write_en;
   logic          read_en;
   logic [AW-1:0] addr;
   logic [7:0]    write_data;
   logic [7:0]    read_data;
   logic          data_ready;
   logic          write_done;
`ifdef REGS_CMD_BRIDGE_ERR_CNT_EN
   logic [7:0]    err_count;
`endif

   always #5 clk = ~clk;

   regs_cmd_bridge #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .write_en(write_en), .read_en(read_en), .addr(addr), .write_data(write_data),
      .read_data(read_data), .data_ready(data_ready), .write_done(write_done)
`ifdef REGS_CMD_BRIDGE_ERR_CNT_EN
      , .err_count(err_count)
`endif
   );

   typedef struct { bit is_wr; int a; int d; int len; } acc_t;
   typedef struct { int b; bit nak; } resp_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] cmd_q[$];
   acc_t       exp_acc[$];
   resp_t      exp_tx[$];
   int         lat_q[$];
   logic [7:0] rx_script[$];
   logic [7:0] ref_mem[DEPTH];
   logic [7:0] slave_mem[DEPTH];

   int  cur_lat = 0, s_cnt = 0, en_len = 0, nak_acc = 0, bp_hold = 0;
   bit  random_on = 0, bp_req = 0, rx_taken = 0, want_en = 0, want_txv = 0;
   bit  prev_en = 0, prev_txv = 0, prev_fire = 0;
   logic [7:0]    prev_txd = 8'h00;
   logic [AW-1:0] prev_addr = '0;
   logic [7:0]    prev_wd = 8'h00;
   acc_t cur_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_resp(input int b, input bit nak);
      resp_t r;
      r.b = b; r.nak = nak;
      exp_tx.push_back(r);
   endtask

   // Slave latency for the next access: 0 = silent, >TMO = too slow, else handshake after lat cycles.
   task automatic next_lat(output int lat);
      int r;
      if (lat_q.size() != 0) begin
         lat = lat_q.pop_front();
      end else begin
         r = $urandom_range(9, 0);
         if (r == 0)      lat = 0;
         else if (r == 1) lat = TMO + 1 + $urandom_range(2, 0);
         else             lat = $urandom_range(TMO, 1);
      end
   endtask

   function automatic logic [7:0] gen_byte();
      int r;
      r = $urandom_range(9, 0);
      if (cmd_q.size() == 0) begin
         if (r < 4)      return 8'h57;
         else if (r < 8) return 8'h52;
         else            return 8'($urandom);
      end else if (cmd_q.size() == 1) begin
         if (r < 8) return 8'($urandom_range(DEPTH - 1, 0));
         else       return 8'($urandom);
      end else begin
         return 8'($urandom);
      end
   endfunction

   // Command-level reference: decides bus access and response once a byte is consumed.
   task automatic model_byte(input logic [7:0] b);
      acc_t ac;
      int   lat;
      bit   ok;
      cmd_q.push_back(b);
      if (cmd_q.size() == 1) begin
         if (b != 8'h57 && b != 8'h52) begin
            push_resp(8'h15, 1'b1); want_txv = 1; cmd_q.delete();
         end
      end else if (cmd_q.size() == 2) begin
         if (int'(b) >= DEPTH) begin
            push_resp(8'h15, 1'b1); want_txv = 1; cmd_q.delete();
         end else if (cmd_q[0] == 8'h52) begin
            next_lat(lat);
            ok = (lat >= 1) && (lat <= TMO);
            ac.is_wr = 1'b0; ac.a = int'(b); ac.d = 0; ac.len = ok ? lat : TMO;
            exp_acc.push_back(ac); cur_lat = lat; want_en = 1;
            if (ok) push_resp(int'(ref_mem[int'(b)]), 1'b0);
            else    push_resp(8'h15, 1'b1);
            cmd_q.delete();
         end
      end else begin
         next_lat(lat);
         ok = (lat >= 1) && (lat <= TMO);
         ac.is_wr = 1'b1; ac.a = int'(cmd_q[1]); ac.d = int'(b); ac.len = ok ? lat : TMO;
         exp_acc.push_back(ac); cur_lat = lat; want_en = 1;
         if (ok) begin
            ref_mem[int'(cmd_q[1])] = b;
            push_resp(8'h06, 1'b0);
         end else begin
            push_resp(8'h15, 1'b1);
         end
         cmd_q.delete();
      end
   endtask

   // One clock: sample outputs #1 after the edge, check, then drive inputs for the next edge.
   task automatic cycle();
      resp_t r;
      bit    hs, en, fire;
      @(posedge clk); #1;
      if (rx_taken) begin rx_valid = 1'b0; rx_taken = 0; end
      en = write_en | read_en;
      chk("en_exclusive", write_en & read_en, 0);
      if (en || tx_valid) chk("rx_ready_busy", rx_ready, 0);
      if (want_en)  begin chk("en_start", en, 1); want_en = 0; end
      if (want_txv) begin chk("nak_start", tx_valid, 1); want_txv = 0; end
      if (prev_txv && !prev_fire) begin
         chk("txv_hold", tx_valid, 1);
         chk("txd_hold", tx_data, prev_txd);
      end
      if (en && !prev_en) begin
         chk("acc_expected", exp_acc.size() != 0, 1);
         if (exp_acc.size() != 0) begin
            cur_acc = exp_acc.pop_front();
            chk("acc_kind", write_en, cur_acc.is_wr);
            chk("acc_addr", addr, cur_acc.a);
            if (cur_acc.is_wr) chk("acc_wdata", write_data, cur_acc.d);
         end
         en_len = 0; s_cnt = 0;
      end
      if (en && prev_en) begin
         chk("addr_hold", addr, prev_addr);
         if (write_en) chk("wdata_hold", write_data, prev_wd);
      end
      if (!en && prev_en) begin
         chk("en_len", en_len, cur_acc.len);
         chk("resp_follows", tx_valid, 1);
      end
      if (en) en_len++;
      // slave
      hs = 1'b0;
      if (en) begin
         s_cnt++;
         hs = (cur_lat != 0) && (s_cnt == cur_lat);
      end else begin
         s_cnt = 0;
      end
      write_done = write_en && hs;
      data_ready = read_en && hs;
      read_data  = 8'($urandom);
      if (data_ready) read_data = slave_mem[addr];
      if (write_done) slave_mem[addr] = write_data;
      if (!write_en && random_on && ($urandom_range(7, 0) == 0)) write_done = 1'b1;
      if (!read_en && random_on && ($urandom_range(7, 0) == 0)) data_ready = 1'b1;
      // transmit side
      if (bp_hold > 0) begin
         tx_ready = 1'b0; bp_hold--;
      end else if (tx_valid && !prev_txv && bp_req) begin
         bp_req = 0; bp_hold = 4; tx_ready = 1'b0;
      end else if (random_on) begin
         tx_ready = ($urandom_range(3, 0) != 0);
      end else begin
         tx_ready = 1'b1;
      end
      fire = tx_valid && tx_ready;
      if (fire) begin
         chk("tx_expected", exp_tx.size() != 0, 1);
         if (exp_tx.size() != 0) begin
            r = exp_tx.pop_front();
            chk("tx_data", tx_data, r.b);
            if (r.nak) nak_acc++;
         end
      end
      // receive side
      if (!rx_valid) begin
         if (rx_script.size() != 0) begin
            rx_data = rx_script.pop_front(); rx_valid = 1'b1;
         end else if ((random_on && ($urandom_range(2, 0) != 0)) || (!random_on && cmd_q.size() != 0)) begin
            rx_data = gen_byte(); rx_valid = 1'b1;
         end
      end
      if (rx_valid && rx_ready) begin
         model_byte(rx_data); rx_taken = 1;
      end
      prev_en = en; prev_txv = tx_valid; prev_fire = fire;
      prev_txd = tx_data; prev_addr = addr; prev_wd = write_data;
   endtask

   task automatic drain(input int max);
      for (int i = 0; i < max; i++) begin
         if (rx_script.size() == 0 && !rx_valid && cmd_q.size() == 0 &&
             exp_tx.size() == 0 && !tx_valid && !write_en && !read_en) break;
         cycle();
      end
      chk("drain_tx", exp_tx.size(), 0);
      chk("drain_acc", exp_acc.size(), 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; read_data = 8'h00;
      data_ready = 1'b0; write_done = 1'b0; rst_n = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = 8'h00; slave_mem[i] = 8'h00; end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_write_en", write_en, 0);
      chk("rst_read_en", read_en, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_addr", addr, 0);
      chk("rst_write_data", write_data, 0);
      rst_n = 1'b1;
      cycle();
      chk("rx_ready_idle", rx_ready, 1);

      // directed: write, read with backpressure, bad command/address, timeout, readback
      rx_script = '{8'h57, 8'h03, 8'hA5}; lat_q = '{1};
      drain(60);
      bp_req = 1;
      rx_script = '{8'h52, 8'h03}; lat_q = '{3};
      drain(60);
      rx_script = '{8'h41, 8'h52, 8'h10, 8'h57, 8'h05, 8'h33, 8'h52, 8'h05}; lat_q = '{0, 1};
      drain(200);
`ifdef REGS_CMD_BRIDGE_ERR_CNT_EN
      chk("err_count_directed", err_count, 3);
`endif

      // random traffic
      random_on = 1;
      repeat (4000) cycle();
      random_on = 0;
      drain(300);

      // reset in the middle of a read
      rx_script = '{8'h52, 8'h07}; lat_q = '{0};
      for (int i = 0; i < 20 && !read_en; i++) cycle();
      chk("read_started", read_en, 1);
      cycle(); cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_read_en", read_en, 0);
      chk("rst_mid_tx_valid", tx_valid, 0);
      chk("rst_mid_rx_ready", rx_ready, 0);
      chk("rst_mid_addr", addr, 0);
      cmd_q.delete(); exp_acc.delete(); exp_tx.delete(); lat_q.delete(); rx_script.delete();
      rx_valid = 1'b0; rx_taken = 0; want_en = 0; want_txv = 0;
      prev_en = 0; prev_txv = 0; prev_fire = 0; s_cnt = 0; bp_hold = 0; bp_req = 0; nak_acc = 0;
      data_ready = 1'b0; write_done = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      rx_script = '{8'h57, 8'h09, 8'h3C}; lat_q = '{2};
      drain(60);
      rx_script = '{8'h52, 8'h09}; lat_q = '{1};
      drain(60);
`ifdef REGS_CMD_BRIDGE_ERR_CNT_EN
      chk("err_count_final", err_count, (nak_acc > 255) ? 255 : nak_acc);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
